// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO pad sequencing controller.
// The GPIO_IRQ_EN macro selects the edge-interrupt logic in gpio_in_sync.
package gpio_pkg;

  localparam int GPIO_NUM_IO_DEFAULT = 32;
  localparam int SETTLE_CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    DRIVE  = 2'd3
  } state_t;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop pad input synchroniser with optional per-pin edge capture.
// Defining GPIO_IRQ_EN builds the history/edge-detect and irq_status registers.
module gpio_in_sync
  import gpio_pkg::*;
#(
  parameter int W = GPIO_NUM_IO_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic [W-1:0] rise_en,
  input  logic [W-1:0] fall_en,
  input  logic [W-1:0] clr,
  output logic [W-1:0] dout,
  output logic [W-1:0] status
);

  logic [W-1:0] meta;

  // Two-stage synchroniser for the asynchronous pad inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= {W{1'b0}};
      dout <= {W{1'b0}};
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [W-1:0] history;
  logic [W-1:0] edge_set;

  // An edge is a difference between the synchronised value and its previous sample
  always_comb begin
    edge_set = (dout & ~history & rise_en) | (~dout & history & fall_en);
  end

  // Edge history and sticky status; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= {W{1'b0}};
      status  <= {W{1'b0}};
    end else begin
      history <= dout;
      status  <= (status & ~clr) | edge_set;
    end
  end
`else
  wire unused_irq_inputs = ^{rise_en, fall_en, clr};
  assign status = {W{1'b0}};
`endif

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Break-before-make sequencer for the GPIO pad output enables and data.
// Edge interrupts are present only when GPIO_IRQ_EN is defined.
module gpio_pad_ctrl
  import gpio_pkg::*;
#(
  parameter int NUM_IO     = GPIO_NUM_IO_DEFAULT,
  parameter int SETTLE_CYC = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [NUM_IO-1:0] cmd_mask,
  input  logic [NUM_IO-1:0] cmd_oe,
  input  logic [NUM_IO-1:0] cmd_data,
  output logic              busy,
  output logic [NUM_IO-1:0] gpio_oe,
  output logic [NUM_IO-1:0] gpio_data_out,
  input  logic [NUM_IO-1:0] gpio_data_in,
  output logic [NUM_IO-1:0] din_sync,
  input  logic [NUM_IO-1:0] irq_rise_en,
  input  logic [NUM_IO-1:0] irq_fall_en,
  input  logic [NUM_IO-1:0] irq_clr,
  output logic [NUM_IO-1:0] irq_status,
  output logic              irq
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);
  localparam logic [SETTLE_CNT_W-1:0] CNT_ZERO    = {SETTLE_CNT_W{1'b0}};

  state_t                  state;
  state_t                  next_state;
  logic [SETTLE_CNT_W-1:0] cnt;
  logic [NUM_IO-1:0]       lat_mask;
  logic [NUM_IO-1:0]       lat_data;
  logic [NUM_IO-1:0]       off_mask;
  logic [NUM_IO-1:0]       on_mask;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: fixed-length release / settle / drive sequence
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          next_state = APPLY;
        end else begin
          next_state = IDLE;
        end
      end
      APPLY:  next_state = SETTLE;
      SETTLE: begin
        if (cnt == CNT_ZERO) begin
          next_state = DRIVE;
        end else begin
          next_state = SETTLE;
        end
      end
      DRIVE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command latch, pad output registers and settle counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lat_mask      <= {NUM_IO{1'b0}};
      lat_data      <= {NUM_IO{1'b0}};
      off_mask      <= {NUM_IO{1'b0}};
      on_mask       <= {NUM_IO{1'b0}};
      gpio_oe       <= {NUM_IO{1'b0}};
      gpio_data_out <= {NUM_IO{1'b0}};
      cnt           <= CNT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // Transition masks are taken against the enables as they stand at accept
            lat_mask <= cmd_mask;
            lat_data <= cmd_data;
            off_mask <= cmd_mask & gpio_oe & ~cmd_oe;
            on_mask  <= cmd_mask & cmd_oe & ~gpio_oe;
          end else begin
            lat_mask <= lat_mask;
          end
        end
        APPLY: begin
          gpio_oe       <= gpio_oe & ~off_mask;
          gpio_data_out <= (gpio_data_out & ~lat_mask) | (lat_data & lat_mask);
          cnt           <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (cnt != CNT_ZERO) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= CNT_ZERO;
          end
        end
        DRIVE: begin
          gpio_oe <= gpio_oe | on_mask;
        end
        default: begin
          cnt <= CNT_ZERO;
        end
      endcase
    end
  end

  gpio_in_sync #(
    .W (NUM_IO)
  ) u_in_sync (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .din     (gpio_data_in),
    .rise_en (irq_rise_en),
    .fall_en (irq_fall_en),
    .clr     (irq_clr),
    .dout    (din_sync),
    .status  (irq_status)
  );

  assign irq = |irq_status;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed scoreboard bench for gpio_pad_ctrl (NUM_IO=32, SETTLE_CYC=2).
// Interrupt expectations follow GPIO_IRQ_EN.
module tb_gpio_pad_ctrl;

  localparam int N = 32;
  localparam int S = 2;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_mask, cmd_oe, cmd_data;
  logic         busy;
  logic [N-1:0] gpio_oe, gpio_data_out, gpio_data_in, din_sync;
  logic [N-1:0] irq_rise_en, irq_fall_en, irq_clr, irq_status;
  logic         irq;

  always #5 sys_clk = ~sys_clk;

  gpio_pad_ctrl #(.NUM_IO(N), .SETTLE_CYC(S)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mask      (cmd_mask),
    .cmd_oe        (cmd_oe),
    .cmd_data      (cmd_data),
    .busy          (busy),
    .gpio_oe       (gpio_oe),
    .gpio_data_out (gpio_data_out),
    .gpio_data_in  (gpio_data_in),
    .din_sync      (din_sync),
    .irq_rise_en   (irq_rise_en),
    .irq_fall_en   (irq_fall_en),
    .irq_clr       (irq_clr),
    .irq_status    (irq_status),
    .irq           (irq)
  );

  typedef struct packed {
    logic [N-1:0] oe;
    logic [N-1:0] dout;
    logic         ready;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  logic [N-1:0] m_oe, m_dout;
  int vectors = 0;
  int miscompares = 0;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue one command (accepted at the next edge) and check every cycle until ready again
  task automatic run_cmd(input string tag, input logic [N-1:0] mask, input logic [N-1:0] oe,
                         input logic [N-1:0] data, input bit hold, input logic [N-1:0] nmask,
                         input logic [N-1:0] noe, input logic [N-1:0] ndata);
    logic [N-1:0] off, on, mid_oe, mid_dout;
    exp_t e;
    string t;
    cmd_mask  = mask;
    cmd_oe    = oe;
    cmd_data  = data;
    cmd_valid = 1'b1;
    off      = mask & m_oe & ~oe;
    on       = mask & oe & ~m_oe;
    mid_oe   = m_oe & ~off;
    mid_dout = (m_dout & ~mask) | (data & mask);
    sb.push_back('{oe: m_oe, dout: m_dout, ready: 1'b0});
    sb_tag.push_back($sformatf("%s_acc", tag));
    for (int k = 1; k <= S + 1; k++) begin
      sb.push_back('{oe: mid_oe, dout: mid_dout, ready: 1'b0});
      sb_tag.push_back($sformatf("%s_mid%0d", tag, k));
    end
    sb.push_back('{oe: mid_oe | on, dout: mid_dout, ready: 1'b1});
    sb_tag.push_back($sformatf("%s_done", tag));
    m_oe   = mid_oe | on;
    m_dout = mid_dout;
    for (int k = 0; k < S + 3; k++) begin
      cyc();
      if (k == 0) begin
        if (hold) begin
          cmd_mask = nmask;
          cmd_oe   = noe;
          cmd_data = ndata;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      e = sb.pop_front();
      t = sb_tag.pop_front();
      chk({t, "_oe"}, gpio_oe, e.oe);
      chk({t, "_dout"}, gpio_data_out, e.dout);
      chk({t, "_ready"}, {31'd0, cmd_ready}, {31'd0, e.ready});
      chk({t, "_busy"}, {31'd0, busy}, {31'd0, ~e.ready});
    end
  endtask

  initial begin
    logic [N-1:0] rm, ro, rd, exp_irq;
    sys_rst      = 1'b1;
    cmd_valid    = 1'b0;
    cmd_mask     = 32'd0;
    cmd_oe       = 32'd0;
    cmd_data     = 32'd0;
    gpio_data_in = 32'd0;
    irq_rise_en  = 32'd0;
    irq_fall_en  = 32'd0;
    irq_clr      = 32'd0;
    m_oe         = 32'd0;
    m_dout       = 32'd0;

    repeat (3) cyc();
    chk("rst_oe", gpio_oe, 32'd0);
    chk("rst_dout", gpio_data_out, 32'd0);
    chk("rst_din_sync", din_sync, 32'd0);
    chk("rst_irq_status", irq_status, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sys_rst = 1'b0;
    cyc();
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

    run_cmd("c1", 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00A5, 1'b0, 32'd0, 32'd0, 32'd0);
    run_cmd("c2", 32'h0000_000F, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("c2_final_oe", gpio_oe, 32'h0000_00F0);

    // Reset while the sequence is settling: nothing of the command survives
    cmd_mask  = 32'h0000_FF00;
    cmd_oe    = 32'h0000_FF00;
    cmd_data  = 32'h0000_1200;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    chk("rm_applied_dout", gpio_data_out, 32'h0000_12A0);
    chk("rm_applied_oe", gpio_oe, 32'h0000_00F0);
    sys_rst = 1'b1;
    #1;
    chk("rm_async_oe", gpio_oe, 32'd0);
    chk("rm_async_dout", gpio_data_out, 32'd0);
    cyc();
    sys_rst = 1'b0;
    repeat (S + 4) cyc();
    chk("rm_post_oe", gpio_oe, 32'd0);
    chk("rm_post_dout", gpio_data_out, 32'd0);
    chk("rm_post_ready", {31'd0, cmd_ready}, 32'd1);
    m_oe   = 32'd0;
    m_dout = 32'd0;

    run_cmd("m0", 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 32'd0);

    // Valid held high across two commands: the second waits for the first
    run_cmd("h1", 32'h0000_FF00, 32'h0000_FF00, 32'h0000_5A00, 1'b1,
            32'hFFFF_0000, 32'hFFFF_0000, 32'hDEAD_0000);
    run_cmd("h2", 32'hFFFF_0000, 32'hFFFF_0000, 32'hDEAD_0000, 1'b0, 32'd0, 32'd0, 32'd0);

    for (int i = 0; i < 4; i++) begin
      rm = $urandom;
      ro = $urandom;
      rd = $urandom;
      run_cmd($sformatf("r%0d", i), rm, ro, rd, 1'b0, 32'd0, 32'd0, 32'd0);
    end

    // Input synchroniser and edge capture
    irq_rise_en  = 32'h0000_0008;
    irq_fall_en  = 32'h0000_0010;
    gpio_data_in = 32'h0000_0028;
    cyc();
    chk("sync_1cyc", din_sync, 32'd0);
    cyc();
    chk("sync_2cyc", din_sync, 32'h0000_0028);
    chk("irq_2cyc", irq_status, 32'd0);
    cyc();
    exp_irq = IRQ_ON ? 32'h0000_0008 : 32'd0;
    chk("irq_rise", irq_status, exp_irq);
    chk("irq_line", {31'd0, irq}, {31'd0, IRQ_ON});

    gpio_data_in = 32'h0000_0000;
    repeat (3) cyc();
    chk("irq_sticky", irq_status, exp_irq);
    gpio_data_in = 32'h0000_0008;
    cyc();
    cyc();
    irq_clr = 32'h0000_0008;
    cyc();
    irq_clr = 32'd0;
    chk("irq_set_wins", irq_status, exp_irq);
    irq_clr = 32'h0000_0008;
    cyc();
    irq_clr = 32'd0;
    chk("irq_cleared", irq_status, 32'd0);
    chk("irq_line_clr", {31'd0, irq}, 32'd0);

    gpio_data_in = 32'h0000_0018;
    repeat (3) cyc();
    chk("irq_no_rise_en", irq_status, 32'd0);
    gpio_data_in = 32'h0000_0008;
    repeat (3) cyc();
    exp_irq = IRQ_ON ? 32'h0000_0010 : 32'd0;
    chk("irq_fall", irq_status, exp_irq);
    chk("din_final", din_sync, 32'h0000_0008);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
